// File: rtl/dot_scan_controller_if.sv
// Sequencer memory read port used by the dot scan controller.
// master: drives selects, samples firing_bit/firing_data.
interface dot_scan_controller_if #(
  parameter int AW = 6
) ();
  logic [AW-1:0] row_select;
  logic [AW-1:0] col_select;
  logic          row_col_select;
  logic          firing_bit;
  logic          firing_data;

  modport master (
    output row_select,
    output col_select,
    output row_col_select,
    input  firing_bit,
    input  firing_data
  );

  modport slave (
    input  row_select,
    input  col_select,
    input  row_col_select,
    output firing_bit,
    output firing_data
  );
endinterface

// File: rtl/dot_scan_controller.sv
// Dot scan engine: sweeps a window of the dot array, pulses firing dots.
// Ports: clock/reset_n, host control+config, mem (sequencer read port),
// drive_en/drive_data pads, busy/done/frame_count status.
// Macro DOT_SCAN_SKIP_IDLE_EN: non-firing dots take 2 cycles.
module dot_scan_controller #(
  parameter int MEM_LENGTH         = 48,
  parameter int MEM_ADDRESS_LENGTH = 6,
  parameter int TIME_BITS          = 16
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic                          start,
  input  logic                          stop,
  input  logic                          continuous,
  input  logic                          col_major_idx,
  input  logic [MEM_ADDRESS_LENGTH-1:0] row_last,
  input  logic [MEM_ADDRESS_LENGTH-1:0] col_last,
  input  logic [TIME_BITS-1:0]          pulse_width,
  input  logic [TIME_BITS-1:0]          dead_time,
  dot_scan_controller_if.master         mem,
  output logic                          drive_en,
  output logic                          drive_data,
  output logic                          busy,
  output logic                          done,
  output logic [15:0]                   frame_count
);
  localparam int AW = MEM_ADDRESS_LENGTH;
  localparam int CW = TIME_BITS + 1;
  localparam logic [AW-1:0] LAST = AW'(MEM_LENGTH - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SAMPLE, S_PULSE, S_DEAD, S_ADVANCE, S_DONE
  } state_t;

  state_t         state_q, state_d;
  logic [AW-1:0]  row_q, row_d;
  logic [AW-1:0]  col_q, col_d;
  logic [AW-1:0]  row_last_q, row_last_d;
  logic [AW-1:0]  col_last_q, col_last_d;
  logic [TIME_BITS-1:0] pw_q, pw_d;
  logic [TIME_BITS-1:0] dt_q, dt_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           cont_q, cont_d;
  logic           rcs_q, rcs_d;
  logic           drive_en_q, drive_en_d;
  logic           drive_data_q, drive_data_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic [15:0]    frame_q, frame_d;
  logic [CW-1:0]  pw1;

  // pulse length is never shorter than one cycle
  assign pw1 = (pw_q == '0) ? CW'(1) : {1'b0, pw_q};

  always_comb begin
    state_d    = state_q;
    row_d      = row_q;
    col_d      = col_q;
    row_last_d = row_last_q;
    col_last_d = col_last_q;
    pw_d       = pw_q;
    dt_d       = dt_q;
    cnt_d      = cnt_q;
    cont_d     = cont_q;
    rcs_d      = rcs_q;
    frame_d    = frame_q;
    if (stop) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            state_d    = S_SAMPLE;
            cont_d     = continuous;
            rcs_d      = col_major_idx;
            row_last_d = (row_last > LAST) ? LAST : row_last;
            col_last_d = (col_last > LAST) ? LAST : col_last;
            pw_d       = pulse_width;
            dt_d       = dead_time;
            row_d      = '0;
            col_d      = '0;
            frame_d    = '0;
          end
        end
        S_SAMPLE: begin
          if (mem.firing_bit) begin
            state_d = S_PULSE;
            cnt_d   = pw1 - CW'(1);
          end else begin
`ifdef DOT_SCAN_SKIP_IDLE_EN
            state_d = S_ADVANCE;
`else
            // idle slot spans pulse + dead time to keep cadence
            state_d = S_DEAD;
            cnt_d   = pw1 + {1'b0, dt_q} - CW'(1);
`endif
          end
        end
        S_PULSE: begin
          if (cnt_q == '0) begin
            if (dt_q == '0) begin
              state_d = S_ADVANCE;
            end else begin
              state_d = S_DEAD;
              cnt_d   = {1'b0, dt_q} - CW'(1);
            end
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end
        S_DEAD: begin
          if (cnt_q == '0) state_d = S_ADVANCE;
          else cnt_d = cnt_q - CW'(1);
        end
        S_ADVANCE: begin
          state_d = S_SAMPLE;
          if (col_q != col_last_q) begin
            col_d = col_q + AW'(1);
          end else if (row_q != row_last_q) begin
            col_d = '0;
            row_d = row_q + AW'(1);
          end else begin
            frame_d = frame_q + 16'd1;
            if (cont_q) begin
              row_d = '0;
              col_d = '0;
            end else begin
              state_d = S_DONE;
            end
          end
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
    drive_en_d   = (state_d == S_PULSE);
    drive_data_d = 1'b0;
    if (state_d == S_PULSE)
      drive_data_d = (state_q == S_SAMPLE) ? mem.firing_data
                                           : drive_data_q;
    busy_d = (state_d != S_IDLE) && (state_d != S_DONE);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      row_q        <= '0;
      col_q        <= '0;
      row_last_q   <= '0;
      col_last_q   <= '0;
      pw_q         <= '0;
      dt_q         <= '0;
      cnt_q        <= '0;
      cont_q       <= 1'b0;
      rcs_q        <= 1'b0;
      drive_en_q   <= 1'b0;
      drive_data_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      frame_q      <= '0;
    end else begin
      state_q      <= state_d;
      row_q        <= row_d;
      col_q        <= col_d;
      row_last_q   <= row_last_d;
      col_last_q   <= col_last_d;
      pw_q         <= pw_d;
      dt_q         <= dt_d;
      cnt_q        <= cnt_d;
      cont_q       <= cont_d;
      rcs_q        <= rcs_d;
      drive_en_q   <= drive_en_d;
      drive_data_q <= drive_data_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      frame_q      <= frame_d;
    end
  end

  assign mem.row_select     = row_q;
  assign mem.col_select     = col_q;
  assign mem.row_col_select = rcs_q;
  assign drive_en           = drive_en_q;
  assign drive_data         = drive_data_q;
  assign busy               = busy_q;
  assign done               = done_q;
  assign frame_count        = frame_q;
endmodule

// File: tb/tb_dot_scan_controller.sv
// Testbench for dot_scan_controller: scenario table plus
// hand-written reset/stop/continuous sequences.
module tb_dot_scan_controller;
  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        continuous = 1'b0;
  logic        col_major_idx = 1'b0;
  logic [5:0]  row_last = '0;
  logic [5:0]  col_last = '0;
  logic [15:0] pulse_width = '0;
  logic [15:0] dead_time = '0;
  logic        drive_en, drive_data, busy, done;
  logic [15:0] frame_count;

  bit fmap [0:63][0:63];
  bit dmap [0:63][0:63];

  dot_scan_controller_if #(.AW(6)) mem_if ();
  assign mem_if.firing_bit  = fmap[mem_if.row_select][mem_if.col_select];
  assign mem_if.firing_data = dmap[mem_if.row_select][mem_if.col_select];

  dot_scan_controller dut (
    .clock(clock), .reset_n(reset_n), .start(start), .stop(stop),
    .continuous(continuous), .col_major_idx(col_major_idx),
    .row_last(row_last), .col_last(col_last),
    .pulse_width(pulse_width), .dead_time(dead_time),
    .mem(mem_if), .drive_en(drive_en), .drive_data(drive_data),
    .busy(busy), .done(done), .frame_count(frame_count)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_err = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // 0 all fire, data (r+c)&1; 1 only (1,0); 2 (0,0)+(47,47); 3 none
  task automatic set_pattern(input int pat);
    for (int r = 0; r < 64; r++)
      for (int c = 0; c < 64; c++) begin
        fmap[r][c] = 1'b0;
        dmap[r][c] = 1'b0;
        unique case (pat)
          0: begin fmap[r][c] = 1'b1; dmap[r][c] = ((r + c) % 2) == 1; end
          1: if (r == 1 && c == 0) begin fmap[r][c] = 1'b1; dmap[r][c] = 1'b1; end
          2: begin
            if (r == 0 && c == 0) begin fmap[r][c] = 1'b1; dmap[r][c] = 1'b1; end
            if (r == 47 && c == 47) fmap[r][c] = 1'b1;
          end
          default: ;
        endcase
      end
  endtask

  // returns at the observation point of cycle 1 (first SAMPLE)
  task automatic start_scan(input int rl, input int cl, input int pw,
                            input int dt, input bit cont, input bit cmi);
    row_last      = 6'(rl);
    col_last      = 6'(cl);
    pulse_width   = 16'(pw);
    dead_time     = 16'(dt);
    continuous    = cont;
    col_major_idx = cmi;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  typedef struct {
    int rl, cl, pw, dt, pat, cmi;
    int exp_done, exp_pulses, exp_on, exp_first, exp_row, exp_col;
  } scen_t;

  scen_t tbl [6];

  initial begin
    int cyc, dcyc, pulses, on, first, derr, selerr, doneerr;
    logic pen;

`ifdef DOT_SCAN_SKIP_IDLE_EN
    tbl[0] = '{1, 1, 3, 2, 0, 0, 29, 4, 12, 2, 1, 1};
    tbl[1] = '{1, 1, 3, 2, 1, 1, 14, 1, 3, 6, 1, 1};
    tbl[2] = '{63, 63, 0, 0, 2, 0, 4611, 2, 2, 2, 47, 47};
    tbl[3] = '{0, 0, 5, 0, 0, 1, 8, 1, 5, 2, 0, 0};
    tbl[4] = '{0, 2, 2, 3, 3, 0, 7, 0, 0, 0, 0, 2};
    tbl[5] = '{2, 0, 1, 1, 0, 1, 13, 3, 3, 2, 2, 0};
`else
    tbl[0] = '{1, 1, 3, 2, 0, 0, 29, 4, 12, 2, 1, 1};
    tbl[1] = '{1, 1, 3, 2, 1, 1, 29, 1, 3, 16, 1, 1};
    tbl[2] = '{63, 63, 0, 0, 2, 0, 6913, 2, 2, 2, 47, 47};
    tbl[3] = '{0, 0, 5, 0, 0, 1, 8, 1, 5, 2, 0, 0};
    tbl[4] = '{0, 2, 2, 3, 3, 0, 22, 0, 0, 0, 0, 2};
    tbl[5] = '{2, 0, 1, 1, 0, 1, 13, 3, 3, 2, 2, 0};
`endif

    // reset state
    #12;
    chk("rst_drive_en", int'(drive_en), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_frame", int'(frame_count), 0);
    chk("rst_sel", int'({mem_if.row_select, mem_if.col_select}), 0);
    reset_n = 1'b1;
    tick();

    foreach (tbl[i]) begin
      set_pattern(tbl[i].pat);
      start_scan(tbl[i].rl, tbl[i].cl, tbl[i].pw, tbl[i].dt, 1'b0,
                 tbl[i].cmi[0]);
      chk($sformatf("s%0d_busy1", i), int'(busy), 1);
      chk($sformatf("s%0d_rcs", i), int'(mem_if.row_col_select),
          tbl[i].cmi);
      cyc = 1; dcyc = 0; pulses = 0; on = 0; first = 0; derr = 0;
      pen = 1'b0;
      while (dcyc == 0 && cyc <= 8000) begin
        if (drive_en) begin
          if (!pen) begin
            pulses++;
            if (first == 0) first = cyc;
          end
          on++;
          if (drive_data !== dmap[mem_if.row_select][mem_if.col_select])
            derr++;
        end else if (drive_data !== 1'b0) derr++;
        if (done) dcyc = cyc;
        else begin
          if (!busy) derr++;
          pen = drive_en;
          tick();
          cyc++;
        end
      end
      chk($sformatf("s%0d_done_cyc", i), dcyc, tbl[i].exp_done);
      chk($sformatf("s%0d_pulses", i), pulses, tbl[i].exp_pulses);
      chk($sformatf("s%0d_on_cycles", i), on, tbl[i].exp_on);
      chk($sformatf("s%0d_first_rise", i), first, tbl[i].exp_first);
      chk($sformatf("s%0d_data_busy_errs", i), derr, 0);
      chk($sformatf("s%0d_busy_at_done", i), int'(busy), 0);
      chk($sformatf("s%0d_row", i), int'(mem_if.row_select), tbl[i].exp_row);
      chk($sformatf("s%0d_col", i), int'(mem_if.col_select), tbl[i].exp_col);
      chk($sformatf("s%0d_frame", i), int'(frame_count), 1);
      tick();
      chk($sformatf("s%0d_done_pulse", i), int'(done), 0);
      chk($sformatf("s%0d_sel_hold", i),
          int'({mem_if.row_select, mem_if.col_select}),
          (tbl[i].exp_row << 6) | tbl[i].exp_col);
      tick();
    end

    // continuous 1x3, P=1, D=0: 3-cycle dots, 9-cycle frames
    set_pattern(0);
    start_scan(0, 2, 1, 0, 1'b1, 1'b0);
    selerr = 0; doneerr = 0;
    for (int k = 1; k <= 28; k++) begin
      if ((k - 1) % 3 == 0) begin
        if (mem_if.row_select != 6'd0) selerr++;
        if (int'(mem_if.col_select) != ((k - 1) / 3) % 3) selerr++;
      end
      if (done) doneerr++;
      if (k == 27) chk("cont_frame_c27", int'(frame_count), 2);
      if (k == 28) chk("cont_frame_c28", int'(frame_count), 3);
      if (k < 28) tick();
    end
    chk("cont_sel_errs", selerr, 0);
    chk("cont_no_done", doneerr, 0);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("cont_stop_busy", int'(busy), 0);
    chk("cont_stop_frame_hold", int'(frame_count), 3);
    tick();

    // restart clears frame_count; stop mid-pulse of dot (0,1)
    start_scan(1, 1, 5, 2, 1'b0, 1'b0);
    chk("restart_frame", int'(frame_count), 0);
    chk("restart_sel", int'({mem_if.row_select, mem_if.col_select}), 0);
    repeat (11) tick();
    chk("stop_pre_drive_en", int'(drive_en), 1);
    chk("stop_pre_col", int'(mem_if.col_select), 1);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("stop_drive_en", int'(drive_en), 0);
    chk("stop_busy", int'(busy), 0);
    chk("stop_col_hold", int'(mem_if.col_select), 1);
    doneerr = 0;
    for (int k = 0; k < 12; k++) begin
      if (done || busy) doneerr++;
      tick();
    end
    chk("stop_no_done", doneerr, 0);

    // stop wins over start in IDLE
    start = 1'b1;
    stop  = 1'b1;
    tick();
    start = 1'b0;
    stop  = 1'b0;
    chk("start_stop_idle", int'(busy), 0);
    tick();

    // async reset mid-pulse: continuous 1x2, P=10, D=0, 12-cycle dots
    start_scan(0, 1, 10, 0, 1'b1, 1'b1);
    repeat (39) tick();
    chk("prerst_drive_en", int'(drive_en), 1);
    chk("prerst_col", int'(mem_if.col_select), 1);
    chk("prerst_frame", int'(frame_count), 1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_drive_en", int'(drive_en), 0);
    chk("arst_busy", int'(busy), 0);
    chk("arst_sel", int'({mem_if.row_select, mem_if.col_select}), 0);
    chk("arst_frame", int'(frame_count), 0);
    chk("arst_rcs", int'(mem_if.row_col_select), 0);
    tick();
    reset_n = 1'b1;
    repeat (3) tick();
    chk("postrst_idle", int'(busy | drive_en | done), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
